framebuffer_arbiter: RTL

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

---
 rtl/framebuffer_arbiter_pkg.sv | 19 +
 rtl/framebuffer_arbiter_if.sv | 43 ++++
 rtl/framebuffer_arbiter_fifo.sv | 70 +++++++
 rtl/framebuffer_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/framebuffer_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// framebuffer_arbiter_pkg
// Shared definitions for the framebuffer arbiter:
//   state_e          - arbiter state (ST_CLEAR sweeps the RAM to zero, ST_RUN
//                      serves the display and drains buffered capture writes)
//   R_MSB/G_MSB/B_MSB - top bit of each RGB555 colour field in a pixel word
// -----------------------------------------------------------------------------
package framebuffer_arbiter_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int R_MSB = 14;
    localparam int G_MSB = 9;
    localparam int B_MSB = 4;

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// -----------------------------------------------------------------------------
// framebuffer_arbiter_if
// Bundles the display read port, the capture write port, the single-port RAM
// port and the busy flag of the framebuffer arbiter.
//   slave  modport - seen by the arbiter
//   master modport - seen by the surrounding display/capture/RAM logic
// Parameters ADDR_W / DATA_W must match those of the arbiter instance.
// -----------------------------------------------------------------------------
interface framebuffer_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 15
);
    // display read port
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    // capture write port
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    // single-port RAM
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    // status
    logic              busy;

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, ram_q,
        output disp_rdata, disp_rvalid, wr_ready, ram_addr, ram_wdata,
               ram_wren, busy
    );

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data, ram_q,
        input  disp_rdata, disp_rvalid, wr_ready, ram_addr, ram_wdata,
               ram_wren, busy
    );

endinterface

// File: rtl/framebuffer_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// fbarb_fifo
// Synchronous first-in first-out write buffer for the framebuffer arbiter.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   push, din    - enqueue din (ignored when full)
//   pop          - dequeue the head (ignored when empty)
//   dout         - current head entry
//   full, empty  - occupancy flags
// FIFO_DEPTH must be a power of two, at least 2, so the pointers wrap freely.
// Storage is not reset; only the pointers and the count are.
// -----------------------------------------------------------------------------
module fbarb_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 31
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // simultaneous push and pop leaves the occupancy unchanged
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/framebuffer_arbiter.sv
// -----------------------------------------------------------------------------
// framebuffer_arbiter
// Shares one single-port framebuffer RAM between a display reader and a
// capture writer. Display reads always win the port in the same cycle;
// capture writes are buffered in fbarb_fifo and drained on cycles the display
// leaves free, in acceptance order.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   bus (slave)  - display read port, capture write port, RAM port, busy
// Build option FBARB_CLEAR_EN: when defined, the block sweeps zeros into every
// RAM address after reset (state ST_CLEAR) before draining buffered writes.
// When undefined, the block runs directly after reset and no clear logic
// exists.
// -----------------------------------------------------------------------------
module framebuffer_arbiter
    import framebuffer_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clock,
    input logic                  reset,
    framebuffer_arbiter_if.slave bus
);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]  fifo_din, fifo_dout;
    logic              wr_ready;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic              clearing;
    logic [ADDR_W-1:0] clr_addr;

    fbarb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (ENT_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef FBARB_CLEAR_EN
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_write;

    // a clear write happens on every idle cycle of the sweep
    assign clr_write = (state_q == ST_CLEAR) && !bus.disp_req && !reset;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (clr_write) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (&clr_addr_q) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign clearing = (state_q == ST_CLEAR);
    assign clr_addr = clr_addr_q;
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    // accepting writes never depends on the display, only on FIFO space
    assign wr_ready  = !fifo_full && !reset;
    assign fifo_push = bus.wr_valid && wr_ready;
    assign fifo_din  = {bus.wr_addr, bus.wr_data};

    // port mux: display, then clear sweep, then FIFO head, else idle zeros
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wren  = 1'b0;
        fifo_pop  = 1'b0;
        if (bus.disp_req) begin
            ram_addr = bus.disp_addr;
        end else if (clearing) begin
            ram_addr = clr_addr;
            ram_wren = 1'b1;
        end else if (!fifo_empty) begin
            ram_addr  = fifo_dout[ENT_W-1:DATA_W];
            ram_wdata = fifo_dout[DATA_W-1:0];
            ram_wren  = 1'b1;
            fifo_pop  = 1'b1;
        end
        if (reset) begin
            ram_wren = 1'b0;
            fifo_pop = 1'b0;
        end
    end

    assign disp_rvalid_d = bus.disp_req;

    always_ff @(posedge clock) begin
        if (reset) disp_rvalid_q <= 1'b0;
        else       disp_rvalid_q <= disp_rvalid_d;
    end

    assign bus.ram_addr    = ram_addr;
    assign bus.ram_wdata   = ram_wdata;
    assign bus.ram_wren    = ram_wren;
    assign bus.wr_ready    = wr_ready;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.disp_rdata  = disp_rvalid_q ? bus.ram_q : '0;
    assign bus.busy        = clearing || !fifo_empty;

endmodule
